// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//
// Purpose:
//   Time-multiplexes the shot-clock digits (s1/s0) and the score digits
//   (sc1/sc0) onto a common-anode 4-digit seven-segment display.
//   - While the shot clock sits at 00, its two digits blink.
//   - Any BCD code from 10 to 15 is shown as a dash.
//   - All display outputs are registered and lag the scan index and the
//     inputs by one clock.
//
// Ports:
//   clk   in   1  system clock
//   rst   in   1  synchronous reset, active-low
//   s1    in   4  shot-clock tens (BCD)
//   s0    in   4  shot-clock ones (BCD)
//   zero  in   1  shot clock is at 00 (level)
//   sc1   in   4  score tens (BCD)
//   sc0   in   4  score ones (BCD)
//   an    out  4  digit enables, active-low, an[0] = rightmost digit
//   seg   out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp    out  1  decimal point, active-low (lit on the score ones digit)
//
// Parameters:
//   DIGIT_CYCLES  clk cycles each digit stays lit (>= 2)
//   BLINK_CYCLES  clk cycles per blink half-period (>= 2)
//
// Build option:
//   SEG7_LZ_BLANK_EN  when defined, the tens digits (index 1 and index 3)
//                     are blanked if they hold 0 (leading-zero blanking).

module seg7_scan_driver #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] s1,
    input  logic [3:0] s0,
    input  logic       zero,
    input  logic [3:0] sc1,
    input  logic [3:0] sc0,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [RW-1:0] REF_LAST   = RW'(DIGIT_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [6:0]    SEG_BLANK  = 7'b1111111;
    localparam logic [6:0]    SEG_DASH   = 7'b0111111;

    typedef enum logic {PH_ON, PH_OFF} phase_t;

    logic [RW-1:0] refresh_q;
    logic [1:0]    idx_q;
    logic [BW-1:0] blink_cnt_q;
    phase_t        phase_q;
    logic          zero_prev_q;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;
    logic [3:0]    digit;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'd0:    r = 7'b1000000;
            4'd1:    r = 7'b1111001;
            4'd2:    r = 7'b0100100;
            4'd3:    r = 7'b0110000;
            4'd4:    r = 7'b0011001;
            4'd5:    r = 7'b0010010;
            4'd6:    r = 7'b0000010;
            4'd7:    r = 7'b1111000;
            4'd8:    r = 7'b0000000;
            4'd9:    r = 7'b0010000;
            default: r = SEG_DASH;
        endcase
        return r;
    endfunction

    // One-hot-low anode pattern for the current scan index.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_an
            assign an_d[gi] = (idx_q != 2'(gi));
        end
    endgenerate

    always_comb begin
        digit = s0;
        case (idx_q)
            2'd0:    digit = s0;
            2'd1:    digit = s1;
            2'd2:    digit = sc0;
            default: digit = sc1;
        endcase

        seg_d = decode(digit);

        // Only the shot-clock digits blink; the anode keeps scanning so the
        // duty cycle of the score digits is unaffected.
        if (phase_q == PH_OFF && !idx_q[1]) begin
            seg_d = SEG_BLANK;
        end

`ifdef SEG7_LZ_BLANK_EN
        if ((idx_q == 2'd1 && s1 == 4'd0) || (idx_q == 2'd3 && sc1 == 4'd0)) begin
            seg_d = SEG_BLANK;
        end
`endif

        dp_d = (idx_q != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            refresh_q   <= '0;
            idx_q       <= 2'd0;
            blink_cnt_q <= '0;
            phase_q     <= PH_ON;
            zero_prev_q <= 1'b0;
            an_q        <= 4'b1111;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            zero_prev_q <= zero;

            if (refresh_q == REF_LAST) begin
                refresh_q <= '0;
                idx_q     <= idx_q + 2'd1;
            end else begin
                refresh_q <= refresh_q + 1'b1;
            end

            // A fresh rising edge of zero restarts the blink in the visible
            // phase, regardless of where a previous blink run stopped.
            if (!zero || !zero_prev_q) begin
                blink_cnt_q <= '0;
                phase_q     <= PH_ON;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                phase_q     <= (phase_q == PH_ON) ? PH_OFF : PH_ON;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end

            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int DC = 4;
    localparam int BC = 8;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       zero = 1'b0;
    logic [3:0] s1   = 4'd0;
    logic [3:0] s0   = 4'd0;
    logic [3:0] sc1  = 4'd0;
    logic [3:0] sc0  = 4'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    seg7_scan_driver #(
        .DIGIT_CYCLES(DC),
        .BLINK_CYCLES(BC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .s1   (s1),
        .s0   (s0),
        .zero (zero),
        .sc1  (sc1),
        .sc0  (sc0),
        .an   (an),
        .seg  (seg),
        .dp   (dp)
    );

    always #5 clk = ~clk;

    // Reference model: scan position and blink phase are derived purely from
    // the number of edges since reset release and the length of the current
    // run of zero=1 samples.
    logic [6:0] seg_tab [16];
    int         n_m = 0;
    int         k_m = 0;
    logic [3:0] exp_an  = 4'b1111;
    logic [6:0] exp_seg = 7'b1111111;
    logic       exp_dp  = 1'b1;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    function automatic int cur_idx();
        return (n_m / DC) % 4;
    endfunction

    function automatic bit cur_phase_on();
        return (k_m == 0) || ((((k_m - 1) / BC) % 2) == 0);
    endfunction

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] expv);
        total_cnt++;
        assert (got === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %b expected %b", tag, got, expv);
        end
    endtask

    task automatic step(input string tag);
        int         idx;
        bit         on;
        logic [3:0] d;
        @(posedge clk);
        if (!rst) begin
            exp_an  = 4'b1111;
            exp_seg = 7'b1111111;
            exp_dp  = 1'b1;
            n_m     = 0;
            k_m     = 0;
        end else begin
            idx = cur_idx();
            on  = cur_phase_on();
            case (idx)
                0:       d = s0;
                1:       d = s1;
                2:       d = sc0;
                default: d = sc1;
            endcase
            exp_an      = 4'b1111;
            exp_an[idx] = 1'b0;
            exp_dp      = (idx != 2);
            exp_seg     = seg_tab[d];
            if (!on && idx < 2) exp_seg = 7'b1111111;
`ifdef SEG7_LZ_BLANK_EN
            if ((idx == 1 && s1 == 4'd0) || (idx == 3 && sc1 == 4'd0)) exp_seg = 7'b1111111;
`endif
            n_m++;
            k_m = zero ? k_m + 1 : 0;
        end
        #1;
        chk({tag, "_an"},  {3'b000, an}, {3'b000, exp_an});
        chk({tag, "_seg"}, seg, exp_seg);
        chk({tag, "_dp"},  {6'd0, dp}, {6'd0, exp_dp});
        $display("step %-8s n=%0d an=%b seg=%b dp=%b", tag, n_m, an, seg, dp);
    endtask

    initial begin
        logic [3:0] tp_an  [5];
        logic [6:0] tp_seg [5];
        int         guard;

        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;

        // Reset state
        rst = 1'b0;
        repeat (3) step("reset");

        // Basic scan: s1=1 s0=0 sc1=2 sc0=7
        tp_an[0] = 4'b1110; tp_seg[0] = 7'b1000000;
        tp_an[1] = 4'b1101; tp_seg[1] = 7'b1111001;
        tp_an[2] = 4'b1011; tp_seg[2] = 7'b1111000;
        tp_an[3] = 4'b0111; tp_seg[3] = 7'b0100100;
        tp_an[4] = 4'b1110; tp_seg[4] = 7'b1000000;
        s1 = 4'd1; s0 = 4'd0; sc1 = 4'd2; sc0 = 4'd7; zero = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step("scan");
            chk("tp_an",  {3'b000, an}, {3'b000, tp_an[i / 4]});
            chk("tp_seg", seg, tp_seg[i / 4]);
            chk("tp_dp",  {6'd0, dp}, {6'd0, (i / 4 == 2) ? 1'b0 : 1'b1});
        end

        // Invalid codes show a dash
        s0 = 4'd12; sc1 = 4'd15;
        repeat (16) step("dash");

        // Blink at 00
        s1 = 4'd0; s0 = 4'd0; zero = 1'b1;
        repeat (40) step("blink");

        // Drop zero during the OFF phase
        guard = 0;
        while (cur_phase_on() && guard < 40) begin
            step("seekoff");
            guard++;
        end
        chk("off_phase_reached", {6'd0, cur_phase_on() ? 1'b1 : 1'b0}, 7'd0);
        zero = 1'b0;
        repeat (10) step("unblink");
        total_cnt++;
        assert (dut.blink_cnt_q == '0) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL blink_cnt_zero: observed %0d expected 0", dut.blink_cnt_q);
        end

        // Reset mid-slot at index 2
        s1 = 4'd4; s0 = 4'd5; sc1 = 4'd6; sc0 = 4'd8;
        guard = 0;
        while (cur_idx() != 2 && guard < 20) begin
            step("seek2");
            guard++;
        end
        step("mid2");
        rst = 1'b0;
        step("midrst");
        rst = 1'b1;
        repeat (10) step("restart");

        // Leading-zero pattern
        s1 = 4'd0; s0 = 4'd9; sc1 = 4'd0; sc0 = 4'd3; zero = 1'b0;
        repeat (20) step("lz");

        // Randomised run
        for (int i = 0; i < 800; i++) begin
            s1  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            s0  = 4'($urandom_range(0, 15));
            sc1 = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            sc0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) zero = ~zero;
            rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            step("rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the shot-clock BCD counter (s1/s0/zero) and of the score BCD digits.
- Time-multiplexes four digits onto the board's common-anode 4-digit seven-segment display.
- Blinks the shot-clock digits when the counter reaches 00 and shows a dash for any invalid BCD code.
- Purely a display stage: no feedback into the game logic.

Parameters:
- DIGIT_CYCLES, 100000, clk cycles each digit stays lit (≥2).
- BLINK_CYCLES, 25000000, clk cycles per blink half-period (≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- s1  in  4  shot-clock tens, BCD.
- s0  in  4  shot-clock ones, BCD.
- zero  in  1  shot clock at 00; level, from the counter.
- sc1  in  4  score tens, BCD.
- sc0  in  4  score ones, BCD.
- an  out  4  digit enables, active-low; an[0] is the rightmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset (rst==0 at a clk edge):
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Refresh counter=0, digit index=0, blink counter=0, blink phase=ON, zero_d=0.
- Refresh counter:
  - Counts 0..DIGIT_CYCLES-1, then wraps to 0.
  - On wrap, the digit index increments mod 4 (3→0).
- Digit mapping:
  - index 0 → s0, an=1110
  - index 1 → s1, an=1101
  - index 2 → sc0, an=1011, dp=0 (score/clock separator)
  - index 3 → sc1, an=0111
  - dp=1 for every index other than 2.
- Output timing:
  - an, seg and dp are registered and reflect the index and input values of the previous cycle (1-cycle latency).
  - First cycle after reset release: an=1110 and seg=decode(s0).
  - An index change appears on an/seg exactly one cycle after the refresh wrap.
  - an and seg change in the same cycle; no intermediate glitch state is allowed.
- Decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 → dash 0111111.
- Blink:
  - zero_d registers zero every cycle.
  - Rising edge (zero & ~zero_d): blink counter←0, phase←ON, so the display always starts blinking from the visible phase.
  - While zero=1: blink counter counts 0..BLINK_CYCLES-1; on wrap, phase toggles.
  - While zero=0: blink counter held at 0, phase held ON.
  - Phase OFF and index ∈ {0,1}: seg=1111111. an still cycles normally, which keeps brightness uniform.
  - Score digits (index 2,3) never blink.
- Inputs are not required to be stable across a digit slot; the value used is whatever is present at the sampling edge.
- Reset asserted mid-scan returns all state to reset values on that edge; there is no partial state.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - Index 1 with s1==0 → seg=1111111 (e.g. "9" is shown, not "09").
  - Index 3 with sc1==0 → seg=1111111.
  - At 00 the ones digit still shows "0"; it blinks as above.
  - An invalid tens code still shows a dash.
- Not defined: every digit is always decoded, including leading zeros.

Test Plan (DIGIT_CYCLES=4, BLINK_CYCLES=8):
- Reset, then release with s1=1, s0=0, sc1=2, sc0=7, zero=0:
  - Cycle 1: an=1110, seg=1000000.
  - After 4 cycles: an=1101, seg=1111001.
  - Then an=1011, seg=1111000, dp=0.
  - Then an=0111, seg=0100100.
  - Then wraps to an=1110.
- Drive s0=12 at index 0 → seg=0111111 (dash); same check for sc1=15 at index 3.
- Drive zero 0→1 with s1=0, s0=0:
  - seg for index 0/1 is 1000000 for 8 cycles, then 1111111 for 8 cycles, repeating.
  - Index 2/3 are unaffected.
- Drop zero to 1→0 during the OFF phase → next index-0 slot shows decode(s0) immediately; blink counter reads 0.
- Assert rst for 1 cycle mid-slot at index 2 → next cycle an=1111, seg=1111111, dp=1; after release, the scan restarts at index 0.
- With SEG7_LZ_BLANK_EN, s1=0, s0=9, sc1=0, sc0=3:
  - Index 1 seg=1111111, index 0 seg=0010000.
  - Index 3 seg=1111111, index 2 seg=0110000.
- Without the macro: index 1 and index 3 seg=1000000.
